// File: rtl/tpu_pkg.sv
// Shared TinyTPU definitions: default datapath widths and the control bundle
// that travels alongside each operand beat through the MAC pipeline.
package tpu_pkg;

    localparam int D_W_DEF   = 16;
    localparam int ACC_W_DEF = 40;

    typedef struct packed {
        logic valid;
        logic init;
        logic last;
        logic sgn;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{valid: 1'b0, init: 1'b0, last: 1'b0, sgn: 1'b0};

endpackage

// File: rtl/mac_mul.sv
// Stage 1 of mac_pe: signed/unsigned D_W x D_W multiply with the stream mode
// latched on init, registered together with the beat's control bundle.
module mac_mul
    import tpu_pkg::*;
#(
    parameter int D_W = D_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             init,
    input  logic             last,
    input  logic             in_signed,
    input  logic [D_W-1:0]   in_x,
    input  logic [D_W-1:0]   in_y,
    output logic [2*D_W-1:0] prod,
    output ctrl_t            ctrl
);

    logic             mode_q, mode_d;
    logic [2*D_W-1:0] prod_q, prod_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             sgn_s;
    logic [2*D_W-1:0] xe_s, ye_s;

    // Operands are widened to 2*D_W first so one unsigned multiplier yields the
    // correct low 2*D_W product bits for both modes.
    always_comb begin
        sgn_s  = init ? in_signed : mode_q;
        xe_s   = {{D_W{in_x[D_W-1] & sgn_s}}, in_x};
        ye_s   = {{D_W{in_y[D_W-1] & sgn_s}}, in_y};
        prod_d = in_valid ? (xe_s * ye_s) : prod_q;
        mode_d = (in_valid && init) ? in_signed : mode_q;
        ctrl_d = '{valid: in_valid, init: init, last: last, sgn: sgn_s};
    end

    // Stage-1 pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            prod_q <= {(2*D_W){1'b0}};
            ctrl_q <= CTRL_IDLE;
        end else begin
            mode_q <= mode_d;
            prod_q <= prod_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign prod = prod_q;
    assign ctrl = ctrl_q;

endmodule

// File: rtl/mac_pe.sv
// TinyTPU multiply-accumulate processing element: operand/control passthrough,
// accumulate stage and result publish. Define MAC_SAT_EN for saturating accumulation.
module mac_pe
    import tpu_pkg::*;
#(
    parameter int D_W   = D_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             init,
    input  logic             last,
    input  logic             in_signed,
    input  logic [D_W-1:0]   in_x,
    input  logic [D_W-1:0]   in_y,
    output logic [D_W-1:0]   out_x,
    output logic [D_W-1:0]   out_y,
    output logic             out_valid,
    output logic             out_init,
    output logic             out_last,
    output logic             out_signed,
    output logic [ACC_W-1:0] out_z,
    output logic             z_valid,
    output logic             ovf
);

    localparam int P_W = 2 * D_W;
    localparam logic [ACC_W-1:0] FILL = {ACC_W{1'b1}} << P_W;

    if (ACC_W < 2 * D_W) begin : g_bad_acc_w
        $error("mac_pe: ACC_W must be at least 2*D_W");
    end

    logic [D_W-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
    ctrl_t            pass_q, pass_d;
    logic [ACC_W-1:0] acc_q, acc_d, out_z_q, out_z_d;
    logic             pub_q, pub_d, z_valid_q, z_valid_d;
    logic [P_W-1:0]   prod_s;
    ctrl_t            ctrl_s;
    logic [ACC_W-1:0] ext_s, base_s, new_acc_s;

    mac_mul #(.D_W(D_W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .init      (init),
        .last      (last),
        .in_signed (in_signed),
        .in_x      (in_x),
        .in_y      (in_y),
        .prod      (prod_s),
        .ctrl      (ctrl_s)
    );

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] MAX_S = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_S = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] MAX_U = {ACC_W{1'b1}};

    logic             sticky_q, sticky_d, ovf_q, ovf_d;
    logic [ACC_W:0]   sum_s;
    logic             beat_ovf_s;
    logic [ACC_W-1:0] sat_val_s;
`endif

    // Accumulate stage: extend product, add onto acc (or restart on init)
    always_comb begin
        ext_s = ACC_W'(prod_s);
        if (ctrl_s.sgn && prod_s[P_W-1]) begin
            ext_s = ext_s | FILL;
        end else begin
            ext_s = ext_s;
        end
        base_s = ctrl_s.init ? {ACC_W{1'b0}} : acc_q;
`ifdef MAC_SAT_EN
        sum_s = {1'b0, base_s} + {1'b0, ext_s};
        if (ctrl_s.sgn) begin
            beat_ovf_s = (base_s[ACC_W-1] == ext_s[ACC_W-1]) &&
                         (sum_s[ACC_W-1] != ext_s[ACC_W-1]);
            sat_val_s  = ext_s[ACC_W-1] ? MIN_S : MAX_S;
        end else begin
            beat_ovf_s = sum_s[ACC_W];
            sat_val_s  = MAX_U;
        end
        new_acc_s = beat_ovf_s ? sat_val_s : sum_s[ACC_W-1:0];
        sticky_d  = ctrl_s.valid ? ((ctrl_s.init ? 1'b0 : sticky_q) | beat_ovf_s) : sticky_q;
        ovf_d     = pub_q ? sticky_q : ovf_q;
`else
        new_acc_s = base_s + ext_s;
`endif
        acc_d     = ctrl_s.valid ? new_acc_s : acc_q;
        pub_d     = ctrl_s.valid && ctrl_s.last;
        z_valid_d = pub_q;
        out_z_d   = pub_q ? acc_q : out_z_q;
        out_x_d   = in_x;
        out_y_d   = in_y;
        pass_d    = '{valid: in_valid, init: init, last: last, sgn: in_signed};
    end

    // Passthrough, accumulator and publish registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x_q   <= {D_W{1'b0}};
            out_y_q   <= {D_W{1'b0}};
            pass_q    <= CTRL_IDLE;
            acc_q     <= {ACC_W{1'b0}};
            pub_q     <= 1'b0;
            z_valid_q <= 1'b0;
            out_z_q   <= {ACC_W{1'b0}};
`ifdef MAC_SAT_EN
            sticky_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            pass_q    <= pass_d;
            acc_q     <= acc_d;
            pub_q     <= pub_d;
            z_valid_q <= z_valid_d;
            out_z_q   <= out_z_d;
`ifdef MAC_SAT_EN
            sticky_q  <= sticky_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_valid  = pass_q.valid;
    assign out_init   = pass_q.init;
    assign out_last   = pass_q.last;
    assign out_signed = pass_q.sgn;
    assign out_z      = out_z_q;
    assign z_valid    = z_valid_q;
`ifdef MAC_SAT_EN
    assign ovf        = ovf_q;
`else
    assign ovf        = 1'b0;
`endif

endmodule

// File: doc/mac_pe.md
# mac_pe

Pipelined, parametrised multiply-accumulate processing element for the TinyTPU systolic array. It supersedes the single-cycle MAC cell with configurable accumulator width, per-stream signed/unsigned mode, valid-qualified beats, explicit stream framing (init/last), a registered result strobe and optional saturation. Operands and control are forwarded to the east/south neighbours with one cycle of latency so array tiling is unchanged.

## Interface
- D_W, 16: operand width (in_x, in_y).
- ACC_W, 40: accumulator/result width; must be ≥ 2*D_W (elaboration error otherwise).
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- in_valid, input, 1: beat qualifier; all other inputs are ignored for accumulation when low.
- init, input, 1: first beat of a stream; overrides the accumulator.
- last, input, 1: final beat of a stream; publishes the result.
- in_signed, input, 1: operand interpretation, sampled on the init beat.
- in_x / in_y, input, D_W: operands from the west/north.
- out_x / out_y, output, D_W: operand passthrough.
- out_valid / out_init / out_last / out_signed, output, 1 each: control passthrough.
- out_z, output, ACC_W: stream result, held until the next publish.
- z_valid, output, 1: one-cycle strobe marking a new out_z.
- ovf, output, 1: overflow flag for the stream last published.

## Operation
- Reset (rst_n low): all outputs and internal state go to 0 immediately, without waiting for a clock edge. In-flight beats are discarded. No z_valid is issued for a stream interrupted by reset.
- Passthrough: every edge, out_x/out_y/out_valid/out_init/out_last/out_signed load the corresponding inputs, regardless of in_valid.
- Stage 1 (multiply): on a valid beat, register the full 2*D_W product. It is signed or unsigned per the stream mode. The stream mode is in_signed when init=1, otherwise the mode latched at the last init. Register alongside it valid, init and last.
- Stage 2 (accumulate): for a valid stage-1 beat:
  - Extend the product to ACC_W (sign-extend in signed mode, zero-extend otherwise).
  - If init: acc ← product and clear the overflow state. Otherwise acc ← acc + product.
  - If last: out_z ← new acc value, z_valid ← 1, ovf ← the stream's sticky overflow including this beat.
- Invalid beats (bubbles) propagate through the pipeline and leave acc, out_z and ovf unchanged.
- init and last on the same beat: single-product stream. The result is published.
- last with no prior init since reset: the beat accumulates onto the current acc (0 after reset).
- init arriving mid-stream: the stream restarts and the earlier partial sum is dropped silently.
- Overflow detection: a beat overflows if the true sum falls outside the ACC_W range for the stream mode, i.e. signed [-2^(ACC_W-1), 2^(ACC_W-1)-1] or unsigned [0, 2^ACC_W-1].

## Timing
- Passthrough latency: 1 cycle.
- Result latency: a beat with last=1 sampled at edge t produces out_z/z_valid=1 after edge t+2.
- z_valid is high for exactly one cycle per published stream. It is 0 on every cycle with no publish.
- Full throughput: one valid beat per cycle, with no stall.
- Back-to-back streams (last on beat k, init on beat k+1) produce z_valid on consecutive cycles with independent results.

## Configuration
- MAC_SAT_EN defined:
  - On overflow, acc clamps to the bound for the stream mode (max or min).
  - Accumulation continues from the clamped value.
  - ovf reports sticky overflow per stream.
- MAC_SAT_EN undefined:
  - acc wraps modulo 2^ACC_W.
  - ovf is tied to 0 and the overflow logic is not built.

## Structure
- Shared package tpu_pkg holds the default D_W/ACC_W constants and a typedef for the stage control bundle (valid, init, last, signed).
- Sub-module mac_mul holds stage 1 (signed/unsigned D_W×D_W multiply plus control register). mac_pe instantiates it and implements passthrough, accumulate, saturation and publish.

## Test plan
- Unsigned stream, D_W=16, ACC_W=40:
  - Stimulus: (3,4,init), (5,6), (7,8,last).
  - Response: out_z=98 and one z_valid pulse exactly two cycles after the last beat.
- Single-beat signed versus unsigned:
  - Stimulus: x=0xFFFE, y=3, init+last with in_signed=1. Response: out_z=0xFFFFFFFFFA (-6).
  - Stimulus: the same beat with in_signed=0. Response: out_z=196602.
- Bubbles:
  - Stimulus: the stream from the first scenario with in_valid=0 cycles inserted between beats.
  - Response: out_z=98, out_valid mirrors in_valid delayed by one cycle, and no extra z_valid.
- Overflow, ACC_W=32:
  - Stimulus: unsigned (0xFFFF,0xFFFF,init), (0xFFFF,0xFFFF,last).
  - Response with MAC_SAT_EN: out_z=0xFFFFFFFF, ovf=1.
  - Response without MAC_SAT_EN: out_z=0xFFFC0002, ovf=0.
- Reset mid-stream:
  - Stimulus: rst_n pulsed low after two beats, then (1,1,init+last).
  - Response: all outputs 0 during reset, no stale z_valid, then out_z=1.
- Back-to-back streams:
  - Stimulus: (2,2,init+last) immediately followed by (3,3,init+last).
  - Response: z_valid high on two consecutive cycles with out_z=4, then 9.
